// File: rtl/bram_tester_pkg.sv
// Shared types and helpers for the block-RAM pattern tester:
// FSM state encoding and the seed-derived data pattern.
package bram_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Wide enough for any supported data/address width; callers slice the result.
    localparam int PAT_W = 32;

    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                                 input logic [PAT_W-1:0] addr);
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/bram_readback_checker.sv
// Checks each RAM read-back cycle for data, one-cycle DO_VALID timing and idle-zero DO;
// keeps a saturating error count and the read address of the first failing cycle.
module bram_readback_checker
    import bram_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  mem_re,
    input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_do,
    input  logic                  mem_do_valid,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    logic                  re_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  err_seen;
    logic [PAT_W-1:0]      exp_full;
    logic [DATA_WIDTH-1:0] expected;
    logic                  fail;

    assign exp_full = pattern(PAT_W'(seed), PAT_W'(rd_addr_q));
    assign expected = exp_full[DATA_WIDTH-1:0];

    assign fail = (mem_do_valid != re_q)
               || ( re_q && (mem_do != expected))
               || (!re_q && (mem_do != '0));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_q           <= 1'b0;
            rd_addr_q      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
        end else begin
            re_q      <= mem_re;
            rd_addr_q <= mem_rd_addr;
            if (clear) begin
                err_count      <= '0;
                first_err_addr <= '0;
                err_seen       <= 1'b0;
            end else if (enable && fail) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!err_seen) begin
                    first_err_addr <= rd_addr_q;
                    err_seen       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_pattern_tester.sv
// Drives a one-cycle dual-port block RAM with a seed-derived write pass followed by a
// full read-back pass, and reports DONE/PASS plus error statistics from the checker.
module bram_pattern_tester
    import bram_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_do,
    input  logic                  mem_do_valid
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [DATA_WIDTH-1:0] seed_q, seed_nxt;
    logic                  start_ok;
    logic                  last_addr;
    logic [PAT_W-1:0]      wr_pat;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_addr = (addr == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr   <= '0;
            seed_q <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            seed_q <= seed_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        seed_nxt  = seed_q;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = ST_WRITE;
                    addr_nxt  = '0;
                    seed_nxt  = seed;
                end
            end
            ST_WRITE: begin
                addr_nxt = addr + ADDR_WIDTH'(1);
                if (last_addr) state_nxt = ST_READ;
            end
            ST_READ: begin
                addr_nxt = addr + ADDR_WIDTH'(1);
                if (last_addr) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // RAM-side drive is gated per phase so idle outputs stay at zero.
    assign wr_pat      = pattern(PAT_W'(seed_q), PAT_W'(addr));
    assign mem_we      = (state == ST_WRITE);
    assign mem_re      = (state == ST_READ);
    assign mem_wr_addr = mem_we ? addr : '0;
    assign mem_di      = mem_we ? wr_pat[DATA_WIDTH-1:0] : '0;
    assign mem_rd_addr = mem_re ? addr : '0;

    assign busy = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    bram_readback_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ERR_W      (ERR_W)
    ) u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (start_ok),
        .enable         ((state == ST_READ) || (state == ST_DRAIN)),
        .seed           (seed_q),
        .mem_re         (mem_re),
        .mem_rd_addr    (mem_rd_addr),
        .mem_do         (mem_do),
        .mem_do_valid   (mem_do_valid),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_bram_pattern_tester.sv
// Directed bench for bram_pattern_tester: a configurable RAM model (healthy, bit-flip,
// two-cycle latency, held DO) plus a second ERR_W=3 instance against an inverting RAM.
module tb_bram_pattern_tester;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [DW-1:0] seed;

    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_di, mem_do;
    logic          mem_we, mem_re, mem_do_valid;

    logic          busy2, done2, pass2;
    logic [2:0]    err_count2;
    logic [AW-1:0] first_err_addr2, mem_wr_addr2, mem_rd_addr2;
    logic [DW-1:0] mem_di2, mem_do2;
    logic          mem_we2, mem_re2, mem_do_valid2;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 healthy, 1 flip DO[0] at addr 5, 2 two-cycle latency, 3 hold DO
    int we_cnt, re_cnt, both_cnt, cyc;

    always #5 clk = ~clk;

    bram_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .mem_di(mem_di), .mem_wr_addr(mem_wr_addr),
        .mem_rd_addr(mem_rd_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_do(mem_do), .mem_do_valid(mem_do_valid)
    );

    bram_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_err_addr(first_err_addr2), .mem_di(mem_di2), .mem_wr_addr(mem_wr_addr2),
        .mem_rd_addr(mem_rd_addr2), .mem_we(mem_we2), .mem_re(mem_re2),
        .mem_do(mem_do2), .mem_do_valid(mem_do_valid2)
    );

    // Main RAM model
    logic [DW-1:0] mem [N];
    logic [DW-1:0] d1, d2;
    logic          v1, v2;

    always @(posedge clk) begin
        if (mem_we) mem[mem_wr_addr] <= mem_di;
        if (!rst_n) begin
            d1 <= '0; v1 <= 1'b0; d2 <= '0; v2 <= 1'b0;
        end else begin
            if (mem_re) begin
                d1 <= mem[mem_rd_addr] ^ ((mode == 1 && mem_rd_addr == 4'd5) ? 8'h01 : 8'h00);
                v1 <= 1'b1;
            end else begin
                d1 <= (mode == 3) ? d1 : '0;
                v1 <= 1'b0;
            end
            d2 <= d1;
            v2 <= v1;
        end
    end

    assign mem_do       = (mode == 2) ? d2 : d1;
    assign mem_do_valid = (mode == 2) ? v2 : v1;

    // Inverting RAM model for the saturation instance
    logic [DW-1:0] mem2 [N];
    logic [DW-1:0] e1;
    logic          w1;

    always @(posedge clk) begin
        if (mem_we2) mem2[mem_wr_addr2] <= mem_di2;
        if (!rst_n) begin
            e1 <= '0; w1 <= 1'b0;
        end else begin
            e1 <= mem_re2 ? ~mem2[mem_rd_addr2] : '0;
            w1 <= mem_re2;
        end
    end

    assign mem_do2       = e1;
    assign mem_do_valid2 = w1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept START, scramble SEED afterwards, and count RAM strobes until DONE.
    task automatic run_test(input logic [DW-1:0] s, output int cycles);
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        seed  = ~s;
        cycles = 0; we_cnt = 0; re_cnt = 0; both_cnt = 0;
        while (!done && cycles < 100) begin
            we_cnt += int'(mem_we);
            re_cnt += int'(mem_re);
            if (mem_we && mem_re) both_cnt++;
            step();
            cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; seed = '0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_pass",  32'(pass), 32'd0);
        check("rst_err",   32'(err_count), 32'd0);
        check("rst_first", 32'(first_err_addr), 32'd0);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_di",    32'(mem_di), 32'd0);

        // 1: healthy RAM
        mode = 0;
        run_test(8'hA5, cyc);
        check("t1_cycles", 32'(cyc), 32'd33);
        check("t1_pass",   32'(pass), 32'd1);
        check("t1_err",    32'(err_count), 32'd0);
        check("t1_we_cnt", 32'(we_cnt), 32'd16);
        check("t1_re_cnt", 32'(re_cnt), 32'd16);
        check("t1_both",   32'(both_cnt), 32'd0);
        // 6: ERR_W=3 instance against inverting RAM, same run
        check("t6_done",   32'(done2), 32'd1);
        check("t6_err",    32'(err_count2), 32'd7);
        check("t6_pass",   32'(pass2), 32'd0);
        check("t6_first",  32'(first_err_addr2), 32'd0);
        step(); step(); step();
        check("t1_done_held", 32'(done), 32'd1);

        // 2: single bit flip at address 5
        mode = 1;
        run_test(8'hA5, cyc);
        check("t2_err",   32'(err_count), 32'd1);
        check("t2_first", 32'(first_err_addr), 32'd5);
        check("t2_pass",  32'(pass), 32'd0);

        // 3: two-cycle latency, every checked READ/DRAIN edge after the first fails
        mode = 2;
        run_test(8'h5A, cyc);
        check("t3_err",   32'(err_count), 32'd16);
        check("t3_first", 32'(first_err_addr), 32'd0);
        check("t3_pass",  32'(pass), 32'd0);

        // 4: DO held while RE=0, second run sees 0xAA left over from run one
        mode = 3;
        run_test(8'hA5, cyc);
        check("t4a_pass", 32'(pass), 32'd1);
        run_test(8'h3C, cyc);
        check("t4b_err",   32'(err_count), 32'd1);
        check("t4b_first", 32'(first_err_addr), 32'd0);
        check("t4b_pass",  32'(pass), 32'd0);

        // 5: START re-pulsed mid-WRITE is ignored
        mode  = 0;
        seed  = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            start = (k == 4);
            step();
        end
        start = 1'b0;
        check("t5_done_32", 32'(done), 32'd0);
        step();
        check("t5_done_33", 32'(done), 32'd1);
        check("t5_pass",    32'(pass), 32'd1);

        // START held high: restarts as soon as DONE is reached
        seed  = 8'h66;
        start = 1'b1;
        step();
        for (int k = 1; k <= 33; k++) step();
        check("t5_hold_done", 32'(done), 32'd1);
        step();
        check("t5_hold_restart", {30'd0, busy, done}, 32'd2);
        start = 1'b0;

        // Reset mid-WRITE at address 7
        for (int k = 0; k < 7; k++) step();
        check("t5_wr_addr7", 32'(mem_wr_addr), 32'd7);
        check("t5_di_addr7", 32'(mem_di), 32'h61);
        rst_n = 1'b0;
        step();
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_err",  32'(err_count), 32'd0);
        check("t5_rst_we",   32'(mem_we), 32'd0);
        rst_n = 1'b1;
        step();
        run_test(8'hC3, cyc);
        check("t5_re_cycles", 32'(cyc), 32'd33);
        check("t5_re_pass",   32'(pass), 32'd1);
        check("t5_re_err",    32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
